// File: rtl/s011hd1p_x32y2d128_bw_sram_if.sv
// Access bundle for the 64x128 bit-write SRAM macro.
// Groups the active-low controls, address, data and read-data lines.
interface s011hd1p_x32y2d128_bw_sram_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
);
  logic              cen;
  logic              wen;
  logic [DATA_W-1:0] bwen;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;

  modport master (
    output cen,
    output wen,
    output bwen,
    output a,
    output d,
    input  q
  );

  modport slave (
    input  cen,
    input  wen,
    input  bwen,
    input  a,
    input  d,
    output q
  );
endinterface

// File: rtl/s011hd1p_x32y2d128_bw_sram.sv
// Single-port 64x128 SRAM model with per-bit write enable, registered Q.
// Optional SRAM_RANDOM_Q_EN drives LFSR garbage on Q on non-read cycles.
module s011hd1p_x32y2d128_bw_sram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2**ADDR_W
) (
  output logic [DATA_W-1:0] Q,
  input  logic              CLK,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [DATA_W-1:0] BWEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic              RSTN
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;
  logic              rd;
  logic              wr;

  assign rd = !CEN && WEN;
  assign wr = !CEN && !WEN;
  assign Q  = q_q;

`ifdef SRAM_RANDOM_Q_EN
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic        fb;

  // Fibonacci LFSR, taps 32,22,2,1
  always_comb begin
    fb     = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    lfsr_d = {lfsr_q[30:0], fb};
  end

  // LFSR state, reset to a fixed seed
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) lfsr_q <= 32'hACE12468;
    else       lfsr_q <= lfsr_d;
  end
`endif

  // Next read data: load on read, otherwise hold or scramble
  always_comb begin
    q_d = q_q;
    if (rd) begin
      q_d = mem_q[A];
    end else begin
`ifdef SRAM_RANDOM_Q_EN
      q_d = {(DATA_W/32){lfsr_q}};
`else
      q_d = q_q;
`endif
    end
  end

  // Read data register, cleared asynchronously by reset
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) q_q <= '0;
    else       q_q <= q_d;
  end

  // Array write with bit mask; contents survive reset
  always_ff @(posedge CLK) begin
    if (RSTN && wr) begin
      mem_q[A] <= (D & ~BWEN) | (mem_q[A] & BWEN);
    end
  end

endmodule

// File: tb/tb_s011hd1p_x32y2d128_bw_sram.sv
// Self-checking bench for the 64x128 bit-write SRAM.
// Directed plan steps followed by randomized traffic against a model.
module tb_s011hd1p_x32y2d128_bw_sram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit [127:0] mem_m [64];
  bit [127:0] q_m = '0;
  bit [31:0]  lfsr_m = 32'hACE12468;

  localparam logic [127:0] P5 =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] LOW16 =
    {{112{1'b1}}, 16'h0000};

  s011hd1p_x32y2d128_bw_sram_if #(.ADDR_W(6), .DATA_W(128)) sif ();

  s011hd1p_x32y2d128_bw_sram dut (
    .Q    (sif.q),
    .CLK  (clk),
    .CEN  (sif.cen),
    .WEN  (sif.wen),
    .BWEN (sif.bwen),
    .A    (sif.a),
    .D    (sif.d),
    .RSTN (rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] exp);
    checks++;
    assert (sif.q === exp) else begin
      errors++;
      $error("FAIL %s: q=%h expected=%h", tag, sif.q, exp);
    end
  endtask

  task automatic cyc(input logic cen, input logic wen,
                     input logic [127:0] bw, input logic [5:0] a,
                     input logic [127:0] d, input string tag);
    sif.cen  = cen;
    sif.wen  = wen;
    sif.bwen = bw;
    sif.a    = a;
    sif.d    = d;
    @(posedge clk);
    if (rst_n) begin
      if (!cen && wen) begin
        q_m = mem_m[a];
      end else begin
        if (!cen) mem_m[a] = (d & ~bw) | (mem_m[a] & bw);
`ifdef SRAM_RANDOM_Q_EN
        q_m = {4{lfsr_m}};
`endif
      end
`ifdef SRAM_RANDOM_Q_EN
      lfsr_m = {lfsr_m[30:0],
                lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0]};
`endif
    end
    #1;
    chk(tag, q_m);
  endtask

  task automatic rd(input logic [5:0] a, input string tag);
    cyc(1'b0, 1'b1, ONES, a, '0, tag);
  endtask

  task automatic wr(input logic [5:0] a, input logic [127:0] d,
                    input logic [127:0] bw, input string tag);
    cyc(1'b0, 1'b0, bw, a, d, tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b1, 1'b0, '0, 6'd0, ONES, tag);
  endtask

  initial begin
    logic [127:0] held;
    logic [127:0] rbw;
    logic [127:0] rd_v;
    sif.cen  = 1'b1;
    sif.wen  = 1'b1;
    sif.bwen = ONES;
    sif.a    = '0;
    sif.d    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", 128'h0);
    cyc(1'b0, 1'b0, '0, 6'd5, ONES, "write_in_reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SRAM_RANDOM_Q_EN
    idle("lfsr_idle0");
    chk("lfsr_seed", {4{32'hACE12468}});
    idle("lfsr_idle1");
`endif

    wr(6'd5, P5, '0, "full_write");
    rd(6'd5, "full_read");
    chk("full_read_const", P5);

    wr(6'd7, ONES, '0, "fill7");
    wr(6'd7, '0, LOW16, "mask_write");
    rd(6'd7, "mask_read");
    chk("mask_read_const", LOW16);

    wr(6'd9, 128'h5555, ONES, "noop_write");
    rd(6'd9, "noop_read");

    rd(6'd5, "hold_read");
    held = q_m;
    idle("hold_idle0");
    idle("hold_idle1");
    idle("hold_idle2");
    wr(6'd9, 128'hDEAD_BEEF, '0, "hold_write");
`ifndef SRAM_RANDOM_Q_EN
    chk("hold_const", held);
`endif
    rd(6'd9, "raw_9");

    wr(6'd0, {4{32'hA5A5_0F0F}}, '0, "w0");
    wr(6'd63, {4{32'h3C3C_F00D}}, '0, "w63");
    rd(6'd0, "b2b_0");
    rd(6'd63, "b2b_63");
    chk("b2b_63_const", {4{32'h3C3C_F00D}});
    rd(6'd0, "b2b_0b");

    rd(6'd5, "pre_reset");
    #2;
    rst_n = 1'b0;
    q_m = '0;
    lfsr_m = 32'hACE12468;
    #1;
    chk("async_reset", 128'h0);
    wr(6'd5, '0, '0, "ignored_write");
    rd(6'd5, "ignored_read");
    #2;
    rst_n = 1'b1;
    rd(6'd5, "after_reset");
    chk("after_reset_const", P5);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] k;
      k = 3'($urandom_range(0, 7));
      unique case (1'b1)
        (k == 3'd0): rbw = '0;
        (k == 3'd1): rbw = ONES;
        default:     rbw = {$urandom, $urandom, $urandom, $urandom};
      endcase
      rd_v = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          rbw, 6'($urandom_range(0, 63)), rd_v, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
